// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter/sequencer with bounded burst lock.
// One transfer at a time; read data is captured the cycle after the read strobe.

module bus_arbiter_checker (
    input logic clk,
    input logic rst_n,
    input logic bus_re,
    input logic bus_we,
    input logic bus_oe,
    input logic m0_gnt,
    input logic m1_gnt
);

    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(bus_re && bus_we));
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) !(m0_gnt && m1_gnt));
    a_oe_follows_we: assert property (@(posedge clk) disable iff (!rst_n) (bus_oe == bus_we));

endmodule

module bus_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_re,
    output logic              bus_we,
    output logic              bus_oe,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_RDATA = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    state_t            state_r;
    logic              last_served_r;
    logic              we_r;
    logic [HOLD_W-1:0] hold_cnt_r;

    logic              arb_valid_s;
    logic              arb_mst_s;
    logic              arb_keep_s;
    logic              prev_s;
    logic              own_req_s;
    logic              own_lock_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    // Choose the next owner from requests sampled in IDLE or DONE
    always_comb begin
        arb_valid_s = 1'b0;
        arb_mst_s   = 1'b0;
        arb_keep_s  = 1'b0;
        // In DONE the current owner becomes last_served at this same edge
        prev_s      = (state_r == ST_DONE) ? owner : last_served_r;
        own_req_s   = owner ? m1_req  : m0_req;
        own_lock_s  = owner ? m1_lock : m0_lock;
        if ((state_r == ST_DONE) && own_req_s && own_lock_s &&
            (int'(hold_cnt_r) < (MAX_HOLD - 1))) begin
            arb_valid_s = 1'b1;
            arb_mst_s   = owner;
            arb_keep_s  = 1'b1;
        end else if (m0_req && m1_req) begin
            arb_valid_s = 1'b1;
            arb_mst_s   = ~prev_s;
        end else if (m0_req) begin
            arb_valid_s = 1'b1;
            arb_mst_s   = 1'b0;
        end else if (m1_req) begin
            arb_valid_s = 1'b1;
            arb_mst_s   = 1'b1;
        end else begin
            arb_valid_s = 1'b0;
        end
    end

    // Winner's transfer attributes, latched at grant
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        if (arb_mst_s) begin
            sel_we_s    = m1_we;
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
        end else begin
            sel_we_s    = m0_we;
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
        end
    end

    // Sequencer: state, ownership, bus phase and per-master results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            last_served_r <= 1'b1;
            we_r          <= 1'b0;
            hold_cnt_r    <= '0;
            owner         <= 1'b0;
            m0_gnt        <= 1'b0;
            m1_gnt        <= 1'b0;
            m0_done       <= 1'b0;
            m1_done       <= 1'b0;
            m0_rdata      <= '0;
            m1_rdata      <= '0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            bus_re        <= 1'b0;
            bus_we        <= 1'b0;
            bus_oe        <= 1'b0;
        end else begin
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            bus_re  <= 1'b0;
            bus_we  <= 1'b0;
            bus_oe  <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (state_r == ST_DONE) begin
                        last_served_r <= owner;
                    end
                    if (arb_valid_s) begin
                        state_r    <= ST_CMD;
                        owner      <= arb_mst_s;
                        m0_gnt     <= ~arb_mst_s;
                        m1_gnt     <= arb_mst_s;
                        we_r       <= sel_we_s;
                        bus_addr   <= sel_addr_s;
                        bus_wdata  <= sel_wdata_s;
                        bus_we     <= sel_we_s;
                        bus_oe     <= sel_we_s;
                        bus_re     <= ~sel_we_s;
                        hold_cnt_r <= arb_keep_s ? (hold_cnt_r + HOLD_W'(1)) : '0;
                    end else begin
                        state_r <= ST_IDLE;
                        m0_gnt  <= 1'b0;
                        m1_gnt  <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (we_r) begin
                        state_r <= ST_DONE;
                        m0_done <= ~owner;
                        m1_done <= owner;
                    end else begin
                        state_r <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    state_r <= ST_DONE;
                    m0_done <= ~owner;
                    m1_done <= owner;
                    if (owner) begin
                        m1_rdata <= bus_rdata;
                    end else begin
                        m0_rdata <= bus_rdata;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    m0_gnt  <= 1'b0;
                    m1_gnt  <= 1'b0;
                end
            endcase
        end
    end

    bus_arbiter_checker u_checker (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_re (bus_re),
        .bus_we (bus_we),
        .bus_oe (bus_oe),
        .m0_gnt (m0_gnt),
        .m1_gnt (m1_gnt)
    );

endmodule
